// File: rtl/alu_issue.sv
// Operand-issue and write-back front end for a single-stage integer ALU.
// Serially issues OP / OP-IMM words from a 32-entry register file and writes the ALU result back.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [31:0]     bus,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  input  logic [XLEN-1:0] alu_in,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [1:0]      dbg_state
);

  // Handshake: a word is consumed on a rising edge where instr_valid && instr_ready;
  // the producer must hold instr stable with instr_valid high until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  state_t          state;
  logic [XLEN-1:0] regs [32];

  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic            is_op;
  logic            is_imm;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;

  assign rs1_idx     = instr[19:15];
  assign rs2_idx     = instr[24:20];
  assign is_op       = (instr[6:0] == OPC_OP);
  assign is_imm      = (instr[6:0] == OPC_IMM);
  assign imm         = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign instr_ready = reset && (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign dbg_state   = state;

  // x0 is never written, but the read mux keeps it zero regardless of array contents.
  assign rs1_val  = (rs1_idx == 5'd0)  ? '0 : regs[rs1_idx];
  assign rs2_val  = (rs2_idx == 5'd0)  ? '0 : regs[rs2_idx];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bus      <= '0;
      rs1_out  <= '0;
      rs2_out  <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_op || is_imm) begin
              rs1_out <= rs1_val;
              rs2_out <= is_op ? rs2_val : imm;
              // Immediate forms clear funct7 so the ALU never sees SUB/SRA there.
              bus     <= is_op ? instr : {7'b0, instr[24:0]};
              wb_addr <= instr[11:7];
              state   <= EXEC;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          wb_data  <= alu_in;
          wb_valid <= 1'b1;
          state    <= WB;
        end
        WB: begin
          if (wb_addr != 5'd0) regs[wb_addr] <= wb_data;
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the issue port, vector table, write-back scoreboard.
module tb_alu_issue;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic            CLK = 1'b0;
  logic            reset = 1'b0;
  logic            instr_valid = 1'b0;
  logic [31:0]     instr = '0;
  logic            instr_ready;
  logic [31:0]     bus;
  logic [XLEN-1:0] rs1_out;
  logic [XLEN-1:0] rs2_out;
  logic [XLEN-1:0] alu_in;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [4:0]      dbg_addr = '0;
  logic [XLEN-1:0] dbg_data;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;

  logic [36:0] exp_q[$];
  logic [36:0] sb_e;
  logic [31:0] model [32];

  typedef struct {
    logic [31:0] word;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [13];

  alu_issue #(.XLEN(XLEN)) dut (
    .CLK(CLK), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .bus(bus), .rs1_out(rs1_out), .rs2_out(rs2_out), .alu_in(alu_in),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Behavioural single-stage ALU decoding funct3/funct7 from bus
  always_comb begin
    alu_in = '0;
    case (bus[14:12])
      3'b000: alu_in = bus[30] ? (rs1_out - rs2_out) : (rs1_out + rs2_out);
      3'b001: alu_in = rs1_out << rs2_out[4:0];
      3'b010: alu_in = {31'b0, ($signed(rs1_out) < $signed(rs2_out))};
      3'b011: alu_in = {31'b0, (rs1_out < rs2_out)};
      3'b100: alu_in = rs1_out ^ rs2_out;
      3'b101: begin
        if (bus[30]) alu_in = $signed(rs1_out) >>> rs2_out[4:0];
        else         alu_in = rs1_out >> rs2_out[4:0];
      end
      3'b110: alu_in = rs1_out | rs2_out;
      default: alu_in = rs1_out & rs2_out;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write-back must match the oldest pending expectation
  always @(negedge CLK) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got addr %0d data %h expected no write-back", wb_addr, wb_data);
      end else begin
        sb_e = exp_q.pop_front();
        check("wb_addr", 32'(wb_addr), 32'(sb_e[36:32]));
        check("wb_data", wb_data, sb_e[31:0]);
      end
    end
  end

  // Driver: call just after a falling edge; returns 1ns after the accepting edge
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("issue_ready", 32'(instr_ready), 32'd1);
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [31:0] w, input logic [4:0] rd, input logic [31:0] d);
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ebus;
    e1   = model[w[19:15]];
    e2   = (w[6:0] == OPC_IMM) ? {{20{w[31]}}, w[31:20]} : model[w[24:20]];
    ebus = (w[6:0] == OPC_IMM) ? {7'b0, w[24:0]} : w;
    exp_q.push_back({rd, d});
    issue(w);
    @(negedge CLK);
    check("exec_state", 32'(dbg_state), 32'd1);
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("exec_wb_valid", 32'(wb_valid), 32'd0);
    check("exec_bus", bus, ebus);
    check("exec_rs1", rs1_out, e1);
    check("exec_rs2", rs2_out, e2);
    @(negedge CLK);
    check("wb_state", 32'(dbg_state), 32'd2);
    check("wb_valid_latency", 32'(wb_valid), 32'd1);
    check("wb_ready", 32'(instr_ready), 32'd0);
    if (rd != 5'd0) model[rd] = d;
    @(negedge CLK);
    check("idle_ready", 32'(instr_ready), 32'd1);
    dbg_addr = rd;
    #1;
    check("dbg_after_wb", dbg_data, model[rd]);
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check(name, dbg_data, model[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    vecs[0]  = '{32'h00500093, 5'd1,  32'h00000005};  // ADDI x1,x0,5
    vecs[1]  = '{32'hFFD00113, 5'd2,  32'hFFFFFFFD};  // ADDI x2,x0,-3
    vecs[2]  = '{32'h002081B3, 5'd3,  32'h00000002};  // ADD  x3,x1,x2
    vecs[3]  = '{32'h40208233, 5'd4,  32'h00000008};  // SUB  x4,x1,x2
    vecs[4]  = '{32'h7FF00293, 5'd5,  32'h000007FF};  // ADDI x5,x0,0x7FF
    vecs[5]  = '{32'h00108033, 5'd0,  32'h0000000A};  // ADD  x0,x1,x1
    vecs[6]  = '{32'h0020C333, 5'd6,  32'hFFFFFFF8};  // XOR  x6,x1,x2
    vecs[7]  = '{32'h0FF17393, 5'd7,  32'h000000FD};  // ANDI x7,x2,0xFF
    vecs[8]  = '{32'h00112433, 5'd8,  32'h00000001};  // SLT  x8,x2,x1
    vecs[9]  = '{32'h001134B3, 5'd9,  32'h00000000};  // SLTU x9,x2,x1
    vecs[10] = '{32'h40115533, 5'd10, 32'hFFFFFFFF};  // SRA  x10,x2,x1
    vecs[11] = '{32'h00409593, 5'd11, 32'h00000050};  // SLLI x11,x1,4
    vecs[12] = '{32'h40115613, 5'd12, 32'h7FFFFFFE};  // SRAI form, funct7 masked -> logical

    // Reset state
    #12;
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus", bus, 32'd0);
    check("rst_rs1", rs1_out, 32'd0);
    check("rst_rs2", rs2_out, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check_all_regs("rst_dbg");
    @(negedge CLK);

    for (int i = 0; i < 13; i++) run_vec(vecs[i].word, vecs[i].rd, vecs[i].data);

    // Illegal word: one-cycle pulse, no write-back
    @(negedge CLK);
    issue(32'h00000003);
    @(negedge CLK);
    check("illegal_pulse", 32'(illegal), 32'd1);
    check("illegal_state", 32'(dbg_state), 32'd0);
    check("illegal_ready", 32'(instr_ready), 32'd1);
    @(negedge CLK);
    check("illegal_clear", 32'(illegal), 32'd0);

    // Back-to-back illegal accepts
    instr       = 32'h0000007F;
    instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr = 32'h00000003;
    @(negedge CLK);
    check("illegal_b2b_first", 32'(illegal), 32'd1);
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
    @(negedge CLK);
    check("illegal_b2b_second", 32'(illegal), 32'd1);
    @(negedge CLK);
    check("illegal_b2b_clear", 32'(illegal), 32'd0);
    check_all_regs("illegal_regs");
    @(negedge CLK);

    // instr_valid held through EXEC/WB; dependent second word reads the first result
    exp_q.push_back({5'd13, 32'h00000007});
    exp_q.push_back({5'd14, 32'h00000008});
    instr       = 32'h00700693;  // ADDI x13,x0,7
    instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr = 32'h00168713;        // ADDI x14,x13,1
    @(negedge CLK);
    check("hold_exec_ready", 32'(instr_ready), 32'd0);
    @(negedge CLK);
    check("hold_wb_ready", 32'(instr_ready), 32'd0);
    @(negedge CLK);
    check("hold_idle_ready", 32'(instr_ready), 32'd1);
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
    @(negedge CLK);
    check("hold_rs1_bypassless", rs1_out, 32'h00000007);
    @(negedge CLK);
    @(negedge CLK);
    model[13] = 32'h00000007;
    model[14] = 32'h00000008;
    check_all_regs("hold_regs");
    @(negedge CLK);

    // Reset during EXEC aborts the instruction and clears the register file
    issue(32'h002081B3);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(instr_ready), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_bus", bus, 32'd0);
    check("abort_rs1", rs1_out, 32'd0);
    check("abort_rs2", rs2_out, 32'd0);
    check("abort_wb_valid", 32'(wb_valid), 32'd0);
    check("abort_wb_data", wb_data, 32'd0);
    dbg_addr = 5'd1;
    #1;
    check("abort_dbg_x1", dbg_data, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    check_all_regs("abort_regs");
    @(negedge CLK);
    run_vec(32'h00500093, 5'd1, 32'h00000005);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
